// File: rtl/render_frame_ctrl.sv
// Frame-synchronous configuration controller: buffers scene/camera requests and
// commits them only at the start of vertical blank, with optional auto-rotation.
module render_frame_ctrl #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_scene,
    input  logic [15:0] cfg_angle,
    input  logic [7:0]  cfg_step,
    input  logic        auto_rotate,
    output logic [1:0]  scene_select,
    output logic [15:0] cam_angle,
    output logic        frame_start,
    output logic        cfg_applied,
    output logic [15:0] frame_count
);

    localparam logic [10:0] H_DISP_W = 11'(H_DISPLAY);
    localparam logic [9:0]  V_DISP_W = 10'(V_DISPLAY);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic        cond_q, cond_d;
    logic        frame_edge;
    logic        cfg_accept;
    logic        apply_now;

    logic [1:0]  shadow_scene_q, shadow_scene_d;
    logic [15:0] shadow_angle_q, shadow_angle_d;
    logic [7:0]  shadow_step_q,  shadow_step_d;

    logic [1:0]  scene_q, scene_d;
    logic [15:0] angle_q, angle_d;
    logic [7:0]  step_q,  step_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        frame_start_q, frame_start_d;
    logic        cfg_applied_q, cfg_applied_d;

    // Frame edge is the first clk of h_count==0 on the first blanking line; the
    // counters may hold for several clk, so only the rising condition counts.
    // The active-width term is always true at h_count==0 for any sane H_DISPLAY.
    always_comb begin
        cond_d     = (v_count == V_DISP_W) && (h_count == 11'd0) && (h_count < H_DISP_W);
        frame_edge = cond_d && !cond_q;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_accept) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A handshake landing on an edge finds the FSM still in IDLE, so it is held
    // over to the following edge rather than applied immediately.
    always_comb begin
        cfg_ready  = (state_q == ST_IDLE);
        cfg_accept = cfg_valid && (state_q == ST_IDLE);
        apply_now  = frame_edge && (state_q == ST_PENDING);
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        shadow_scene_d = shadow_scene_q;
        shadow_angle_d = shadow_angle_q;
        shadow_step_d  = shadow_step_q;
        scene_d        = scene_q;
        angle_d        = angle_q;
        step_d         = step_q;
        frame_count_d  = frame_count_q;
        frame_start_d  = 1'b0;
        cfg_applied_d  = 1'b0;

        if (cfg_accept) begin
            shadow_scene_d = cfg_scene;
            shadow_angle_d = cfg_angle;
            shadow_step_d  = cfg_step;
        end

        if (frame_edge) begin
            frame_start_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (apply_now) begin
                // Applied angle is taken verbatim; rotation resumes next frame.
                scene_d       = shadow_scene_q;
                angle_d       = shadow_angle_q;
                step_d        = shadow_step_q;
                cfg_applied_d = 1'b1;
            end else if (auto_rotate) begin
                angle_d = angle_q + {{8{step_q[7]}}, step_q};
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q         <= 1'b0;
            shadow_scene_q <= 2'd0;
            shadow_angle_q <= 16'd0;
            shadow_step_q  <= 8'd0;
            scene_q        <= 2'd0;
            angle_q        <= 16'd0;
            step_q         <= 8'd0;
            frame_count_q  <= 16'd0;
            frame_start_q  <= 1'b0;
            cfg_applied_q  <= 1'b0;
        end else begin
            cond_q         <= cond_d;
            shadow_scene_q <= shadow_scene_d;
            shadow_angle_q <= shadow_angle_d;
            shadow_step_q  <= shadow_step_d;
            scene_q        <= scene_d;
            angle_q        <= angle_d;
            step_q         <= step_d;
            frame_count_q  <= frame_count_d;
            frame_start_q  <= frame_start_d;
            cfg_applied_q  <= cfg_applied_d;
        end
    end

    assign scene_select = scene_q;
    assign cam_angle    = angle_q;
    assign frame_start  = frame_start_q;
    assign cfg_applied  = cfg_applied_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_render_frame_ctrl.sv
// Directed, table-driven bench for render_frame_ctrl: each row drives one clk of
// inputs and lists the outputs expected just after that clk edge.
module tb_render_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_scene;
    logic [15:0] cfg_angle;
    logic [7:0]  cfg_step;
    logic        auto_rotate;
    logic [1:0]  scene_select;
    logic [15:0] cam_angle;
    logic        frame_start;
    logic        cfg_applied;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    render_frame_ctrl #(.H_DISPLAY(640), .V_DISPLAY(480)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_count      (h_count),
        .v_count      (v_count),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_scene    (cfg_scene),
        .cfg_angle    (cfg_angle),
        .cfg_step     (cfg_step),
        .auto_rotate  (auto_rotate),
        .scene_select (scene_select),
        .cam_angle    (cam_angle),
        .frame_start  (frame_start),
        .cfg_applied  (cfg_applied),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int v; int val; int sc; int an; int st; int ar;
        int e_rdy; int e_sc; int e_an; int e_fs; int e_ap; int e_fc;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(input int h, v, val, sc, an, st, ar,
                                input int e_rdy, e_sc, e_an, e_fs, e_ap, e_fc);
        vec_t r;
        r = '{h, v, val, sc, an, st, ar, e_rdy, e_sc, e_an, e_fs, e_ap, e_fc};
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input int rdy, sc, an, fs, ap, fc);
        chk("cfg_ready",    idx, int'(cfg_ready),    rdy);
        chk("scene_select", idx, int'(scene_select), sc);
        chk("cam_angle",    idx, int'(cam_angle),    an);
        chk("frame_start",  idx, int'(frame_start),  fs);
        chk("cfg_applied",  idx, int'(cfg_applied),  ap);
        chk("frame_count",  idx, int'(frame_count),  fc);
    endtask

    task automatic drive(input int h, v, val, sc, an, st, ar);
        h_count     = 11'(h);
        v_count     = 10'(v);
        cfg_valid   = 1'(val);
        cfg_scene   = 2'(sc);
        cfg_angle   = 16'(an);
        cfg_step    = 8'(st);
        auto_rotate = 1'(ar);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             h    v  val sc  angle   step ar | rdy sc angle   fs ap fc
        // Two idle frames
        vecs[0]  = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 0, 'h0000, 0, 0, 0);
        vecs[1]  = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 0, 'h0000, 1, 0, 1);
        vecs[2]  = mk(1, 480,  0, 0, 'h0000, 'h00, 0,   1, 0, 'h0000, 0, 0, 1);
        vecs[3]  = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 0, 'h0000, 0, 0, 1);
        vecs[4]  = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 0, 'h0000, 1, 0, 2);
        vecs[5]  = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 0, 'h0000, 0, 0, 2);
        // Mid-frame config, applied at next edge
        vecs[6]  = mk(5,   0,  1, 1, 'h4000, 'h00, 0,   0, 0, 'h0000, 0, 0, 2);
        vecs[7]  = mk(6,   0,  0, 0, 'h0000, 'h00, 0,   0, 0, 'h0000, 0, 0, 2);
        vecs[8]  = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 1, 'h4000, 1, 1, 3);
        vecs[9]  = mk(1, 480,  0, 0, 'h0000, 'h00, 0,   1, 1, 'h4000, 0, 0, 3);
        // Auto-rotate +32 from 0xFFF0 wraps to 0x0010; then -16 from 0x0000
        vecs[10] = mk(5,   0,  1, 2, 'hFFF0, 'h20, 1,   0, 1, 'h4000, 0, 0, 3);
        vecs[11] = mk(0, 480,  0, 0, 'h0000, 'h00, 1,   1, 2, 'hFFF0, 1, 1, 4);
        vecs[12] = mk(5,   0,  0, 0, 'h0000, 'h00, 1,   1, 2, 'hFFF0, 0, 0, 4);
        vecs[13] = mk(0, 480,  0, 0, 'h0000, 'h00, 1,   1, 2, 'h0010, 1, 0, 5);
        vecs[14] = mk(5,   0,  1, 2, 'h0000, 'hF0, 1,   0, 2, 'h0010, 0, 0, 5);
        vecs[15] = mk(0, 480,  0, 0, 'h0000, 'h00, 1,   1, 2, 'h0000, 1, 1, 6);
        vecs[16] = mk(5,   0,  0, 0, 'h0000, 'h00, 1,   1, 2, 'h0000, 0, 0, 6);
        vecs[17] = mk(0, 480,  0, 0, 'h0000, 'h00, 1,   1, 2, 'hFFF0, 1, 0, 7);
        vecs[18] = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 0, 0, 7);
        vecs[19] = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 1, 0, 8);
        vecs[20] = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 0, 0, 8);
        // h_count held at 0 for three clk: one edge only
        vecs[21] = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 1, 0, 9);
        vecs[22] = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 0, 0, 9);
        vecs[23] = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 0, 0, 9);
        vecs[24] = mk(1, 480,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 0, 0, 9);
        vecs[25] = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 2, 'hFFF0, 0, 0, 9);
        // Handshake on the edge cycle; second offer while pending is refused
        vecs[26] = mk(0, 480,  1, 3, 'h1234, 'h00, 0,   0, 2, 'hFFF0, 1, 0, 10);
        vecs[27] = mk(5,   0,  1, 0, 'h5555, 'h00, 0,   0, 2, 'hFFF0, 0, 0, 10);
        vecs[28] = mk(0, 480,  0, 0, 'h0000, 'h00, 0,   1, 3, 'h1234, 1, 1, 11);
        vecs[29] = mk(5,   0,  0, 0, 'h0000, 'h00, 0,   1, 3, 'h1234, 0, 0, 11);

        rst_n = 1'b0;
        drive(5, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_all(-1, 1, 0, 'h0000, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].val, vecs[i].sc, vecs[i].an,
                  vecs[i].st, vecs[i].ar);
            tick();
            $display("step %0d: h=%0d v=%0d val=%0d ar=%0d -> rdy=%0d scene=%0d angle=%04h fs=%0d ap=%0d fc=%0d",
                     i, vecs[i].h, vecs[i].v, vecs[i].val, vecs[i].ar, cfg_ready,
                     scene_select, cam_angle, frame_start, cfg_applied, frame_count);
            chk_all(i, vecs[i].e_rdy, vecs[i].e_sc, vecs[i].e_an,
                    vecs[i].e_fs, vecs[i].e_ap, vecs[i].e_fc);
        end

        // Reset asserted while a config is pending: shadow must be discarded
        drive(5, 0, 1, 1, 'hABCD, 'h05, 0);
        tick();
        chk("pend_ready", 100, int'(cfg_ready), 0);
        drive(6, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: rdy=%0d scene=%0d angle=%04h fc=%0d",
                 cfg_ready, scene_select, cam_angle, frame_count);
        chk_all(101, 1, 0, 'h0000, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 480, 0, 0, 0, 0, 1);
        tick();
        $display("post-reset edge: ap=%0d fs=%0d scene=%0d angle=%04h fc=%0d",
                 cfg_applied, frame_start, scene_select, cam_angle, frame_count);
        chk_all(102, 1, 0, 'h0000, 1, 0, 1);
        drive(5, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 480, 0, 0, 0, 0, 1);
        tick();
        $display("post-reset rotate: angle=%04h fc=%0d", cam_angle, frame_count);
        chk_all(103, 1, 0, 'h0000, 1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
